wt_mem_arbiter: RTL and testbench
=================================

# wt_mem_arbiter

Parametrised N-port request arbiter and return router between write-through L1 cache clients (I$, D$ read/AMO, write buffer, future PTW or prefetch ports) and a single memory adapter (AXI or L1.5). It generalises the fixed two-client adapter plumbing of the cache subsystem to any port count. It adds round-robin fairness, per-port outstanding-transaction limits, port-tagged transaction IDs and return routing by ID. It is instantiated between the caches and the adapter inside the cache subsystem.

## Interface
- NumPorts, 3, number of requesting clients (2..8)
- ReqWidth, 128, request payload bits (opaque: address, size, type, wdata)
- RtrnWidth, 128, return payload bits (opaque)
- TidWidth, 2, client-local transaction ID bits
- MaxOutstanding, 4, per-port limit of in-flight transactions (1..15)
- PortIdxWidth, derived as $clog2(NumPorts), not overridable

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  NumPorts  per-port request valid, level
- req_data_i  in  NumPorts*ReqWidth  per-port payload
- req_tid_i  in  NumPorts*TidWidth  per-port local ID
- ack_o  out  NumPorts  one-hot capture acknowledge
- mem_req_o  out  1  downstream request valid
- mem_ack_i  in  1  downstream accept
- mem_data_o  out  ReqWidth  registered payload
- mem_tid_o  out  PortIdxWidth+TidWidth  {port index, local ID}
- mem_rtrn_vld_i  in  1  return valid, single cycle
- mem_rtrn_data_i  in  RtrnWidth  return payload
- mem_rtrn_tid_i  in  PortIdxWidth+TidWidth  return ID
- rtrn_vld_o  out  NumPorts  one-hot routed return valid
- rtrn_data_o  out  RtrnWidth  return payload, shared by all ports
- rtrn_tid_o  out  TidWidth  local ID of the routed return
- busy_o  out  1  any port has transactions in flight, or output register full
- err_o  out  1  sticky, unexpected return seen

## Operation
- Requester protocol: hold req_i with stable data and ID until ack_o[p] is seen; ack_o is a single-cycle pulse.
- Eligible port: req_i[p]=1 and cnt[p] < MaxOutstanding.
- Capture condition: the output register is empty, or it is full and mem_ack_i=1 in the same cycle (back-to-back).
- On capture:
  - ack_o pulses for the round-robin winner.
  - The winner's payload and {p, tid} are loaded into the output register; mem_req_o=1 from the next cycle.
  - cnt[p] increments.
- Round-robin: a priority pointer starts at port 0 after reset. After a grant to p, the pointer moves to (p+1) mod NumPorts. Without a grant the pointer is unchanged.
- The output register holds mem_req_o, mem_data_o and mem_tid_o stable until mem_ack_i.
- Return path, when mem_rtrn_vld_i=1 with index field q:
  - If q < NumPorts and cnt[q] > 0: the cycle after, rtrn_vld_o[q]=1, rtrn_data_o = registered data, rtrn_tid_o = local ID; cnt[q] decrements.
  - Otherwise: the return is dropped and err_o is set.
- Counters are PortIdx-independent, each 4 bits wide. Capture and return on the same port in the same cycle leaves the count unchanged.
- busy_o = (OR of cnt[p] != 0) | mem_req_o.

## Timing
- Reset values: mem_req_o=0, ack_o=0, rtrn_vld_o=0, err_o=0, busy_o=0, all counters 0, pointer 0. mem_data_o, mem_tid_o, rtrn_data_o and rtrn_tid_o are also cleared to 0.
- Latency:
  - ack_o is combinational in the capture cycle.
  - Request-to-mem_req_o is 1 cycle.
  - Return is 1 cycle, registered.
- Throughput: 1 request per cycle when mem_ack_i is held high; 1 return per cycle.
- Boundary conditions:
  - A port at MaxOutstanding is skipped, without stalling other ports.
  - All ports full: no ack_o; mem_req_o drops after the last mem_ack_i.
- Reset mid-operation: all state clears immediately (asynchronous). Returns arriving after reset find cnt=0 and set err_o. Requesters must not depend on any in-flight capture.
- err_o clears only on reset.

## Test plan
- Single port: req_i[0]=1, tid=2, mem_ack_i=1.
  - Expect ack_o[0] at cycle 0.
  - Expect mem_req_o=1 and mem_tid_o={0,2} at cycle 1.
  - Return {0,2} -> rtrn_vld_o=001, rtrn_tid_o=2 one cycle later; busy_o falls.
- Fairness: all 3 ports request continuously, mem_ack_i=1, returns immediate -> grant order 0,1,2,0,1,2; no port starved.
- Limit, MaxOutstanding=4: port 1 issues 4 requests with no returns -> 5th is not acked, port 2 is still granted. One return to port 1 -> port 1 is acked again within 2 cycles.
- Backpressure: mem_ack_i=0 for 5 cycles -> mem_data_o and mem_tid_o stay stable, no further ack_o. When mem_ack_i=1, the next capture occurs in that same cycle.
- Simultaneous events: capture and return on port 0 in the same cycle -> cnt[0] unchanged. Return with index 3 while NumPorts=3 -> dropped, err_o=1 and sticky.
- Reset mid-flight: 2 transactions outstanding, assert rst_i -> outputs are 0 within the reset cycle. A later return sets err_o.

Source files
------------

// File: rtl/wt_mem_arbiter_if.sv
// Bus bundle between the cache clients, the arbiter and the memory adapter.
// The slave modport is the arbiter's view; master is the surrounding side.
interface wt_mem_arbiter_if #(
  parameter int NumPorts  = 3,
  parameter int ReqWidth  = 128,
  parameter int RtrnWidth = 128,
  parameter int TidWidth  = 2
);
  localparam int PortIdxWidth = $clog2(NumPorts);
  localparam int IdWidth      = PortIdxWidth + TidWidth;

  logic [NumPorts-1:0]          req_i;
  logic [NumPorts*ReqWidth-1:0] req_data_i;
  logic [NumPorts*TidWidth-1:0] req_tid_i;
  logic [NumPorts-1:0]          ack_o;
  logic                         mem_req_o;
  logic                         mem_ack_i;
  logic [ReqWidth-1:0]          mem_data_o;
  logic [IdWidth-1:0]           mem_tid_o;
  logic                         mem_rtrn_vld_i;
  logic [RtrnWidth-1:0]         mem_rtrn_data_i;
  logic [IdWidth-1:0]           mem_rtrn_tid_i;
  logic [NumPorts-1:0]          rtrn_vld_o;
  logic [RtrnWidth-1:0]         rtrn_data_o;
  logic [TidWidth-1:0]          rtrn_tid_o;
  logic                         busy_o;
  logic                         err_o;

  modport slave (
    input  req_i, req_data_i, req_tid_i, mem_ack_i,
           mem_rtrn_vld_i, mem_rtrn_data_i, mem_rtrn_tid_i,
    output ack_o, mem_req_o, mem_data_o, mem_tid_o,
           rtrn_vld_o, rtrn_data_o, rtrn_tid_o, busy_o, err_o
  );

  modport master (
    output req_i, req_data_i, req_tid_i, mem_ack_i,
           mem_rtrn_vld_i, mem_rtrn_data_i, mem_rtrn_tid_i,
    input  ack_o, mem_req_o, mem_data_o, mem_tid_o,
           rtrn_vld_o, rtrn_data_o, rtrn_tid_o, busy_o, err_o
  );
endinterface

// File: rtl/wt_mem_arbiter.sv
// N-port round-robin request arbiter with per-port outstanding limits,
// port-tagged transaction IDs and return routing by ID.
module wt_mem_arbiter #(
  parameter int NumPorts       = 3,
  parameter int ReqWidth       = 128,
  parameter int RtrnWidth      = 128,
  parameter int TidWidth       = 2,
  parameter int MaxOutstanding = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  wt_mem_arbiter_if.slave bus
);
  localparam int PortIdxWidth = $clog2(NumPorts);
  localparam int IdWidth      = PortIdxWidth + TidWidth;

  logic [3:0]              cnt [NumPorts];
  logic [PortIdxWidth-1:0] ptr;
  logic                    out_vld;
  logic [ReqWidth-1:0]     out_data;
  logic [IdWidth-1:0]      out_tid;
  logic [NumPorts-1:0]     rtrn_vld;
  logic [RtrnWidth-1:0]    rtrn_data;
  logic [TidWidth-1:0]     rtrn_tid;
  logic                    err;

  logic [NumPorts-1:0]     eligible;
  logic [NumPorts-1:0]     cnt_nz;
  logic                    grant_found;
  logic [PortIdxWidth-1:0] grant_idx;
  logic                    capture_en;
  logic                    capture;
  logic [NumPorts-1:0]     cnt_inc;
  logic [NumPorts-1:0]     rtrn_hit;
  logic                    rtrn_ok;
  logic [PortIdxWidth-1:0] rtrn_port;

  assign rtrn_port = bus.mem_rtrn_tid_i[IdWidth-1:TidWidth];

  // Per-port eligibility: requesting and below the in-flight limit.
  always_comb begin
    eligible = '0;
    cnt_nz   = '0;
    for (int p = 0; p < NumPorts; p++) begin
      eligible[p] = bus.req_i[p] && (cnt[p] < 4'(MaxOutstanding));
      cnt_nz[p]   = (cnt[p] != 4'd0);
    end
  end

  // Round-robin search starting at the priority pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NumPorts;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PortIdxWidth'(idx);
      end
    end
  end

  // Capture is allowed into an empty register or when the held entry leaves this cycle.
  assign capture_en = !out_vld || bus.mem_ack_i;
  assign capture    = capture_en && grant_found;

  // One-hot grant and return decode; out-of-range or unexpected returns hit no port.
  always_comb begin
    cnt_inc  = '0;
    rtrn_hit = '0;
    for (int p = 0; p < NumPorts; p++) begin
      cnt_inc[p]  = capture && (grant_idx == PortIdxWidth'(p));
      rtrn_hit[p] = bus.mem_rtrn_vld_i && (rtrn_port == PortIdxWidth'(p)) && cnt_nz[p];
    end
    rtrn_ok = |rtrn_hit;
  end

  // In-flight counters; a simultaneous capture and return on one port cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumPorts; p++) cnt[p] <= 4'd0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (cnt_inc[p] && !rtrn_hit[p])      cnt[p] <= cnt[p] + 4'd1;
        else if (rtrn_hit[p] && !cnt_inc[p]) cnt[p] <= cnt[p] - 4'd1;
      end
    end
  end

  // Priority pointer moves past the winner only when something was granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        ptr <= '0;
    else if (capture) ptr <= (grant_idx == PortIdxWidth'(NumPorts - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Output register: loaded on capture, held until the adapter accepts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_tid  <= '0;
    end else if (capture) begin
      out_vld  <= 1'b1;
      out_data <= bus.req_data_i[int'(grant_idx)*ReqWidth +: ReqWidth];
      out_tid  <= {grant_idx, bus.req_tid_i[int'(grant_idx)*TidWidth +: TidWidth]};
    end else if (bus.mem_ack_i) begin
      out_vld  <= 1'b0;
    end
  end

  // Registered return routing and sticky error on unmatched returns.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rtrn_vld  <= '0;
      rtrn_data <= '0;
      rtrn_tid  <= '0;
      err       <= 1'b0;
    end else begin
      rtrn_vld <= rtrn_hit;
      if (rtrn_ok) begin
        rtrn_data <= bus.mem_rtrn_data_i;
        rtrn_tid  <= bus.mem_rtrn_tid_i[TidWidth-1:0];
      end
      if (bus.mem_rtrn_vld_i && !rtrn_ok) err <= 1'b1;
    end
  end

  assign bus.ack_o       = cnt_inc;
  assign bus.mem_req_o   = out_vld;
  assign bus.mem_data_o  = out_data;
  assign bus.mem_tid_o   = out_tid;
  assign bus.rtrn_vld_o  = rtrn_vld;
  assign bus.rtrn_data_o = rtrn_data;
  assign bus.rtrn_tid_o  = rtrn_tid;
  assign bus.err_o       = err;
  assign bus.busy_o      = (|cnt_nz) | out_vld;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Directed bench for wt_mem_arbiter, three ports, narrow payloads.
module tb_wt_mem_arbiter;
  localparam int NP = 3;
  localparam int RW = 16;
  localparam int TW = 2;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  wt_mem_arbiter_if #(.NumPorts(NP), .ReqWidth(RW), .RtrnWidth(RW), .TidWidth(TW)) bus ();

  wt_mem_arbiter #(
    .NumPorts(NP), .ReqWidth(RW), .RtrnWidth(RW), .TidWidth(TW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_i           = '0;
    bus.req_data_i      = '0;
    bus.req_tid_i       = '0;
    bus.mem_ack_i       = 1'b0;
    bus.mem_rtrn_vld_i  = 1'b0;
    bus.mem_rtrn_data_i = '0;
    bus.mem_rtrn_tid_i  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drive_req(input int p, input logic on, input logic [RW-1:0] d, input logic [TW-1:0] t);
    bus.req_i[p]                = on;
    bus.req_data_i[p*RW +: RW]  = d;
    bus.req_tid_i[p*TW +: TW]   = t;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req_o); end
    checks++; if (bus.ack_o !== 3'b000) begin failures++; $display("FAIL reset_ack: got %b expected 000", bus.ack_o); end
    checks++; if (bus.rtrn_vld_o !== 3'b000) begin failures++; $display("FAIL reset_rtrn_vld: got %b expected 000", bus.rtrn_vld_o); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.mem_data_o !== 16'h0000 || bus.mem_tid_o !== 4'h0) begin failures++; $display("FAIL reset_mem_out: got data %h tid %h expected 0/0", bus.mem_data_o, bus.mem_tid_o); end
  endtask

  task automatic test_single();
    do_reset();
    drive_req(0, 1'b1, 16'hA001, 2'd2);
    bus.mem_ack_i = 1'b1;
    settle();
    checks++; if (bus.ack_o !== 3'b001) begin failures++; $display("FAIL single_ack: got %b expected 001", bus.ack_o); end
    tick();
    drive_req(0, 1'b0, 16'h0000, 2'd0);
    settle();
    checks++; if (bus.mem_req_o !== 1'b1) begin failures++; $display("FAIL single_mem_req: got %b expected 1", bus.mem_req_o); end
    checks++; if (bus.mem_tid_o !== 4'b0010) begin failures++; $display("FAIL single_mem_tid: got %b expected 0010", bus.mem_tid_o); end
    checks++; if (bus.mem_data_o !== 16'hA001) begin failures++; $display("FAIL single_mem_data: got %h expected a001", bus.mem_data_o); end
    checks++; if (bus.ack_o !== 3'b000) begin failures++; $display("FAIL single_ack_pulse: got %b expected 000", bus.ack_o); end
    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL single_busy_hi: got %b expected 1", bus.busy_o); end
    tick();
    checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL single_mem_req_drop: got %b expected 0", bus.mem_req_o); end
    bus.mem_rtrn_vld_i  = 1'b1;
    bus.mem_rtrn_tid_i  = 4'b0010;
    bus.mem_rtrn_data_i = 16'hBEEF;
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
    checks++; if (bus.rtrn_vld_o !== 3'b001) begin failures++; $display("FAIL single_rtrn_vld: got %b expected 001", bus.rtrn_vld_o); end
    checks++; if (bus.rtrn_tid_o !== 2'd2) begin failures++; $display("FAIL single_rtrn_tid: got %0d expected 2", bus.rtrn_tid_o); end
    checks++; if (bus.rtrn_data_o !== 16'hBEEF) begin failures++; $display("FAIL single_rtrn_data: got %h expected beef", bus.rtrn_data_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL single_busy_lo: got %b expected 0", bus.busy_o); end
    tick();
    checks++; if (bus.rtrn_vld_o !== 3'b000) begin failures++; $display("FAIL single_rtrn_pulse: got %b expected 000", bus.rtrn_vld_o); end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_ack;
    logic [3:0] exp_tid;
    int         pp;
    do_reset();
    bus.mem_ack_i = 1'b1;
    for (int p = 0; p < NP; p++) drive_req(p, 1'b1, 16'hF000 | 16'(p), 2'(p));
    for (int k = 0; k < 6; k++) begin
      settle();
      exp_ack = 3'b001 << (k % 3);
      checks++; if (bus.ack_o !== exp_ack) begin failures++; $display("FAIL fair_ack[%0d]: got %b expected %b", k, bus.ack_o, exp_ack); end
      if (k > 0) begin
        pp = (k - 1) % 3;
        exp_tid = {pp[1:0], pp[1:0]};
        checks++; if (bus.mem_tid_o !== exp_tid) begin failures++; $display("FAIL fair_tid[%0d]: got %b expected %b", k, bus.mem_tid_o, exp_tid); end
      end
      tick();
    end
    bus.req_i = '0;
  endtask

  task automatic test_limit();
    do_reset();
    bus.mem_ack_i = 1'b1;
    drive_req(1, 1'b1, 16'h1000, 2'd1);
    for (int k = 0; k < MO; k++) begin
      settle();
      checks++; if (bus.ack_o !== 3'b010) begin failures++; $display("FAIL limit_ack[%0d]: got %b expected 010", k, bus.ack_o); end
      tick();
    end
    settle();
    checks++; if (bus.ack_o !== 3'b000) begin failures++; $display("FAIL limit_full: got %b expected 000", bus.ack_o); end
    drive_req(2, 1'b1, 16'h2000, 2'd3);
    settle();
    checks++; if (bus.ack_o !== 3'b100) begin failures++; $display("FAIL limit_skip: got %b expected 100", bus.ack_o); end
    tick();
    drive_req(2, 1'b0, 16'h0000, 2'd0);
    settle();
    checks++; if (bus.ack_o !== 3'b000) begin failures++; $display("FAIL limit_still_full: got %b expected 000", bus.ack_o); end
    checks++; if (bus.mem_tid_o !== 4'b1011) begin failures++; $display("FAIL limit_p2_tid: got %b expected 1011", bus.mem_tid_o); end
    bus.mem_rtrn_vld_i = 1'b1;
    bus.mem_rtrn_tid_i = 4'b0101;
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
    settle();
    checks++; if (bus.rtrn_vld_o !== 3'b010) begin failures++; $display("FAIL limit_rtrn: got %b expected 010", bus.rtrn_vld_o); end
    checks++; if (bus.ack_o !== 3'b010) begin failures++; $display("FAIL limit_reack: got %b expected 010", bus.ack_o); end
    bus.req_i = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mem_ack_i = 1'b0;
    drive_req(0, 1'b1, 16'h1111, 2'd1);
    settle();
    checks++; if (bus.ack_o !== 3'b001) begin failures++; $display("FAIL bp_first_ack: got %b expected 001", bus.ack_o); end
    tick();
    drive_req(0, 1'b0, 16'h0000, 2'd0);
    drive_req(1, 1'b1, 16'h2222, 2'd3);
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++; if (bus.ack_o !== 3'b000) begin failures++; $display("FAIL bp_noack[%0d]: got %b expected 000", k, bus.ack_o); end
      checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_data_o !== 16'h1111 || bus.mem_tid_o !== 4'b0001) begin
        failures++; $display("FAIL bp_hold[%0d]: got req %b data %h tid %b expected 1 1111 0001", k, bus.mem_req_o, bus.mem_data_o, bus.mem_tid_o);
      end
      tick();
    end
    bus.mem_ack_i = 1'b1;
    settle();
    checks++; if (bus.ack_o !== 3'b010) begin failures++; $display("FAIL bp_same_cycle: got %b expected 010", bus.ack_o); end
    tick();
    drive_req(1, 1'b0, 16'h0000, 2'd0);
    settle();
    checks++; if (bus.mem_data_o !== 16'h2222 || bus.mem_tid_o !== 4'b0111) begin
      failures++; $display("FAIL bp_next: got data %h tid %b expected 2222 0111", bus.mem_data_o, bus.mem_tid_o);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.mem_ack_i = 1'b1;
    drive_req(0, 1'b1, 16'h3000, 2'd0);
    settle();
    checks++; if (bus.ack_o !== 3'b001) begin failures++; $display("FAIL simul_ack0: got %b expected 001", bus.ack_o); end
    tick();
    drive_req(0, 1'b0, 16'h0000, 2'd0);
    tick();
    drive_req(0, 1'b1, 16'h3001, 2'd0);
    bus.mem_rtrn_vld_i = 1'b1;
    bus.mem_rtrn_tid_i = 4'b0000;
    settle();
    checks++; if (bus.ack_o !== 3'b001) begin failures++; $display("FAIL simul_ack1: got %b expected 001", bus.ack_o); end
    tick();
    drive_req(0, 1'b0, 16'h0000, 2'd0);
    checks++; if (bus.rtrn_vld_o !== 3'b001) begin failures++; $display("FAIL simul_rtrn1: got %b expected 001", bus.rtrn_vld_o); end
    tick();
    checks++; if (bus.rtrn_vld_o !== 3'b001 || bus.err_o !== 1'b0) begin
      failures++; $display("FAIL simul_cnt_kept: got rtrn %b err %b expected 001 0", bus.rtrn_vld_o, bus.err_o);
    end
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
    checks++; if (bus.rtrn_vld_o !== 3'b000 || bus.err_o !== 1'b1) begin
      failures++; $display("FAIL simul_cnt_empty: got rtrn %b err %b expected 000 1", bus.rtrn_vld_o, bus.err_o);
    end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL simul_busy: got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_bad_index();
    do_reset();
    bus.mem_rtrn_vld_i = 1'b1;
    bus.mem_rtrn_tid_i = 4'b1110;
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
    checks++; if (bus.rtrn_vld_o !== 3'b000) begin failures++; $display("FAIL badidx_rtrn: got %b expected 000", bus.rtrn_vld_o); end
    checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL badidx_err: got %b expected 1", bus.err_o); end
    tick();
    tick();
    checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL badidx_sticky: got %b expected 1", bus.err_o); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.mem_ack_i = 1'b0;
    drive_req(0, 1'b1, 16'h0A0A, 2'd1);
    settle();
    checks++; if (bus.ack_o !== 3'b001) begin failures++; $display("FAIL mid_ack0: got %b expected 001", bus.ack_o); end
    tick();
    drive_req(0, 1'b0, 16'h0000, 2'd0);
    drive_req(1, 1'b1, 16'h0B0B, 2'd2);
    bus.mem_ack_i = 1'b1;
    settle();
    checks++; if (bus.ack_o !== 3'b010) begin failures++; $display("FAIL mid_ack1: got %b expected 010", bus.ack_o); end
    tick();
    drive_req(1, 1'b0, 16'h0000, 2'd0);
    bus.mem_ack_i = 1'b0;
    settle();
    checks++; if (bus.busy_o !== 1'b1 || bus.mem_tid_o !== 4'b0110) begin
      failures++; $display("FAIL mid_inflight: got busy %b tid %b expected 1 0110", bus.busy_o, bus.mem_tid_o);
    end
    rst = 1'b1;
    settle();
    checks++; if (bus.mem_req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.ack_o !== 3'b000) begin
      failures++; $display("FAIL mid_async_clear: got req %b busy %b ack %b expected 0 0 000", bus.mem_req_o, bus.busy_o, bus.ack_o);
    end
    checks++; if (bus.mem_data_o !== 16'h0000 || bus.mem_tid_o !== 4'h0) begin
      failures++; $display("FAIL mid_async_data: got data %h tid %h expected 0/0", bus.mem_data_o, bus.mem_tid_o);
    end
    tick();
    rst = 1'b0;
    tick();
    bus.mem_rtrn_vld_i = 1'b1;
    bus.mem_rtrn_tid_i = 4'b0001;
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
    checks++; if (bus.err_o !== 1'b1 || bus.rtrn_vld_o !== 3'b000) begin
      failures++; $display("FAIL mid_late_rtrn: got err %b rtrn %b expected 1 000", bus.err_o, bus.rtrn_vld_o);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_limit();
    test_backpressure();
    test_simultaneous();
    test_bad_index();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
